// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit owning the architectural HI/LO registers.
// Multi-cycle ops compute their full result at issue into shadow registers and
// commit them to HI/LO when the busy counter expires.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_srcA,
    input  logic [31:0] i_srcB,
    input  logic [3:0]  i_mduOp,
    input  logic        i_valid,
    output logic        o_start,
    output logic        o_busy,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic [31:0] o_result
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e        state, state_next;
    logic [CW-1:0] count, count_next;
    logic          commit;

    logic [31:0]   hi, lo;
    logic [31:0]   shadow_hi, shadow_lo;
    logic          shadow_we;

    logic          is_mul, is_div, is_signed, start;
    logic [63:0]   mul_a, mul_b, product;
    logic          neg_a, neg_b;
    logic [31:0]   mag_a, mag_b, divisor, quot_mag, rem_mag, quot, rem;

    assign is_mul    = (i_mduOp == OP_MULT) || (i_mduOp == OP_MULTU);
    assign is_div    = (i_mduOp == OP_DIV)  || (i_mduOp == OP_DIVU);
    assign is_signed = (i_mduOp == OP_MULT) || (i_mduOp == OP_DIV);

    assign o_busy  = (state == BUSY);
    assign start   = i_valid && !o_busy && (is_mul || is_div);
    assign o_start = start;
    assign o_hi    = hi;
    assign o_lo    = lo;

    // 64-bit product with operands sign- or zero-extended by op.
    always_comb begin
        mul_a   = is_signed ? {{32{i_srcA[31]}}, i_srcA} : {32'd0, i_srcA};
        mul_b   = is_signed ? {{32{i_srcB[31]}}, i_srcB} : {32'd0, i_srcB};
        product = mul_a * mul_b;
    end

    // Signed division done on magnitudes so 0x80000000 / -1 wraps to
    // 0x80000000 with remainder 0; divisor 0 is replaced to keep the divider defined.
    always_comb begin
        neg_a    = is_signed && i_srcA[31];
        neg_b    = is_signed && i_srcB[31];
        mag_a    = neg_a ? (~i_srcA + 32'd1) : i_srcA;
        mag_b    = neg_b ? (~i_srcB + 32'd1) : i_srcB;
        divisor  = (mag_b == 32'd0) ? 32'd1 : mag_b;
        quot_mag = mag_a / divisor;
        rem_mag  = mag_a % divisor;
        quot     = (neg_a ^ neg_b) ? (~quot_mag + 32'd1) : quot_mag;
        rem      = neg_a ? (~rem_mag + 32'd1) : rem_mag;
    end

    // Next-state and counter logic for the busy sequencer.
    always_comb begin
        state_next = state;
        count_next = count;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = BUSY;
                    count_next = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                end
            end
            BUSY: begin
                count_next = count - CW'(1);
                if (count == CW'(1)) begin
                    state_next = IDLE;
                    commit     = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Capture the pending result at issue; divide-by-zero suppresses the commit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shadow_hi <= '0;
            shadow_lo <= '0;
            shadow_we <= 1'b0;
        end else if (start) begin
            shadow_hi <= is_mul ? product[63:32] : rem;
            shadow_lo <= is_mul ? product[31:0]  : quot;
            shadow_we <= is_mul || (i_srcB != 32'd0);
        end
    end

    // Architectural HI/LO: commit from shadows or direct mthi/mtlo writes when idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            if (shadow_we) begin
                hi <= shadow_hi;
                lo <= shadow_lo;
            end
        end else if (i_valid && !o_busy) begin
            if (i_mduOp == OP_MTHI) hi <= i_srcA;
            if (i_mduOp == OP_MTLO) lo <= i_srcA;
        end
    end

    // Read mux for mfhi/mflo; no bypass of same-cycle writes.
    always_comb begin
        o_result = '0;
        if (i_mduOp == OP_MFHI) o_result = hi;
        if (i_mduOp == OP_MFLO) o_result = lo;
    end

endmodule
